// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the hazard / forwarding controller.
package hazard_pkg;

  // Branch-compare operand mux (four-way, ID stage).
  localparam logic [1:0] SEL_RF = 2'b00;
  localparam logic [1:0] SEL_EX = 2'b01;
  localparam logic [1:0] SEL_MA = 2'b10;
  localparam logic [1:0] SEL_WB = 2'b11;

  // ALU operand mux (three-way, EX stage) uses its own narrower encoding.
  localparam logic [1:0] ALU_SEL_RF = 2'b00;
  localparam logic [1:0] ALU_SEL_MA = 2'b01;
  localparam logic [1:0] ALU_SEL_WB = 2'b10;

  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } hz_state_e;

  // Stall lengths never exceed 2+7, so four bits are enough.
  function automatic logic [3:0] max_n(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// One producer-stage vs. one consumer-source compare; x0 never matches.
module fwd_match #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd,
  input  logic              we,
  output logic              hit
);

  assign hit = we && (rd == rs) && (rs != '0);

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Operand-forwarding select plus load-use / branch-on-load stall control.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no stall in flight; hazards detected and stalled combinationally
//   STALL | multi-cycle stall running, wait_q more cycles after this one
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 0,
  parameter int CNT_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs_i,
  input  logic [NUM_SRC-1:0]        id_rs_used_i,
  input  logic                      id_is_branch_i,
  input  logic [NUM_SRC*REG_AW-1:0] ex_rs_i,
  input  logic [REG_AW-1:0]         ex_rd_i,
  input  logic [REG_AW-1:0]         ma_rd_i,
  input  logic [REG_AW-1:0]         wb_rd_i,
  input  logic                      ex_reg_we_i,
  input  logic                      ma_reg_we_i,
  input  logic                      wb_reg_we_i,
  input  logic                      ex_is_load_i,
  input  logic                      ma_is_load_i,
  input  logic                      redirect_i,
  output logic [2*NUM_SRC-1:0]      alu_sel_o,
  output logic [2*NUM_SRC-1:0]      br_sel_o,
  output logic                      stall_o,
  output logic                      ex_bubble_o,
  output logic [CNT_W-1:0]          stall_cnt_o
);

  localparam logic [3:0] N_LOAD_USE = 4'(1 + LOAD_LAT);
  localparam logic [3:0] N_BR_EX    = 4'(2 + LOAD_LAT);
  localparam logic [3:0] N_BR_MA    = 4'(1 + LOAD_LAT);

  hz_state_e   state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [3:0]  need_n;
  logic        detect;
  logic        stall_raw;

  logic [NUM_SRC-1:0] ex_hit_id, ma_hit_id, wb_hit_id;
  logic [NUM_SRC-1:0] ma_hit_ex, wb_hit_ex;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    fwd_match #(.REG_AW(REG_AW)) u_ex_id (
      .rs(id_rs_i[k*REG_AW +: REG_AW]), .rd(ex_rd_i), .we(ex_reg_we_i), .hit(ex_hit_id[k]));
    fwd_match #(.REG_AW(REG_AW)) u_ma_id (
      .rs(id_rs_i[k*REG_AW +: REG_AW]), .rd(ma_rd_i), .we(ma_reg_we_i), .hit(ma_hit_id[k]));
    fwd_match #(.REG_AW(REG_AW)) u_wb_id (
      .rs(id_rs_i[k*REG_AW +: REG_AW]), .rd(wb_rd_i), .we(wb_reg_we_i), .hit(wb_hit_id[k]));
    fwd_match #(.REG_AW(REG_AW)) u_ma_ex (
      .rs(ex_rs_i[k*REG_AW +: REG_AW]), .rd(ma_rd_i), .we(ma_reg_we_i), .hit(ma_hit_ex[k]));
    fwd_match #(.REG_AW(REG_AW)) u_wb_ex (
      .rs(ex_rs_i[k*REG_AW +: REG_AW]), .rd(wb_rd_i), .we(wb_reg_we_i), .hit(wb_hit_ex[k]));
  end

  // Operand mux selects: youngest producing stage wins; loads cannot feed ID compares from EX/MA.
  always_comb begin
    alu_sel_o = '0;
    br_sel_o  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (ma_hit_ex[k])      alu_sel_o[2*k +: 2] = ALU_SEL_MA;
      else if (wb_hit_ex[k]) alu_sel_o[2*k +: 2] = ALU_SEL_WB;
      else                   alu_sel_o[2*k +: 2] = ALU_SEL_RF;

      if (ex_hit_id[k] && !ex_is_load_i)      br_sel_o[2*k +: 2] = SEL_EX;
      else if (ma_hit_id[k] && !ma_is_load_i) br_sel_o[2*k +: 2] = SEL_MA;
      else if (wb_hit_id[k])                  br_sel_o[2*k +: 2] = SEL_WB;
      else                                    br_sel_o[2*k +: 2] = SEL_RF;
    end
  end

  // Required stall length for the ID instruction; zero means no hazard.
  always_comb begin
    need_n = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (id_rs_used_i[k]) begin
        if (ex_hit_id[k] && ex_is_load_i)
          need_n = max_n(need_n, id_is_branch_i ? N_BR_EX : N_LOAD_USE);
        if (id_is_branch_i && ma_hit_id[k] && ma_is_load_i)
          need_n = max_n(need_n, N_BR_MA);
      end
    end
  end

  assign detect    = (need_n != 4'd0);
  assign stall_raw = ((state_q == IDLE) && detect) || (state_q == STALL);
  // A redirect flushes ID anyway, so holding it would only waste a cycle.
  assign stall_o     = rst_n && !redirect_i && stall_raw;
  assign ex_bubble_o = stall_o;

  // Next-state logic; the detection cycle itself is the first stall cycle.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    if (redirect_i) begin
      state_d = IDLE;
      wait_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (need_n > 4'd1) begin
            state_d = STALL;
            wait_d  = need_n - 4'd2;
          end
        end
        STALL: begin
          if (wait_q != 4'd0) wait_d = wait_q - 4'd1;
          else                state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          wait_d  = '0;
        end
      endcase
    end
  end

  // State and wait-counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Saturating count of cycles in which the front end was actually held.
  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cnt_o <= '0;
    else if (stall_o && (stall_cnt_o != {CNT_W{1'b1}}))
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic against a remaining-stall-cycles reference model.
module tb_hazard_fwd_ctrl;

  localparam int AW  = 5;
  localparam int NS  = 2;
  localparam int LAT = 2;
  localparam int CW  = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NS*AW-1:0] id_rs, ex_rs;
  logic [NS-1:0]  id_used;
  logic           id_br;
  logic [AW-1:0]  ex_rd, ma_rd, wb_rd;
  logic           ex_we, ma_we, wb_we, ex_ld, ma_ld, redirect;
  logic [2*NS-1:0] alu_sel, br_sel;
  logic           stall, bubble;
  logic [CW-1:0]  stall_cnt;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  int m_rem    = 0;
  int m_cnt    = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs_i(id_rs), .id_rs_used_i(id_used), .id_is_branch_i(id_br),
    .ex_rs_i(ex_rs), .ex_rd_i(ex_rd), .ma_rd_i(ma_rd), .wb_rd_i(wb_rd),
    .ex_reg_we_i(ex_we), .ma_reg_we_i(ma_we), .wb_reg_we_i(wb_we),
    .ex_is_load_i(ex_ld), .ma_is_load_i(ma_ld), .redirect_i(redirect),
    .alu_sel_o(alu_sel), .br_sel_o(br_sel), .stall_o(stall),
    .ex_bubble_o(bubble), .stall_cnt_o(stall_cnt));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    id_rs = '0; id_used = '0; id_br = 1'b0; ex_rs = '0;
    ex_rd = '0; ma_rd = '0; wb_rd = '0;
    ex_we = 1'b0; ma_we = 1'b0; wb_we = 1'b0;
    ex_ld = 1'b0; ma_ld = 1'b0; redirect = 1'b0;
  endtask

  task automatic clear_ex();
    ex_rd = '0; ex_we = 1'b0; ex_ld = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_all();
    cyc();
    chk_en = 1'b1;
    cyc();
    rst_n = 1'b1;
  endtask

  // ---------------- reference model ----------------
  function automatic bit hit(input logic [AW-1:0] rs, input logic [AW-1:0] rd, input logic we);
    return we && (rd == rs) && (rs != 0);
  endfunction

  function automatic int need_cycles();
    int n;
    logic [AW-1:0] rs;
    n = 0;
    for (int k = 0; k < NS; k++) begin
      rs = id_rs[k*AW +: AW];
      if (id_used[k]) begin
        if (hit(rs, ex_rd, ex_we) && ex_ld && n < 1 + LAT) n = 1 + LAT;
        if (id_br && hit(rs, ex_rd, ex_we) && ex_ld && n < 2 + LAT) n = 2 + LAT;
        if (id_br && hit(rs, ma_rd, ma_we) && ma_ld && n < 1 + LAT) n = 1 + LAT;
      end
    end
    return n;
  endfunction

  function automatic logic [1:0] exp_alu(input int k);
    logic [AW-1:0] rs;
    rs = ex_rs[k*AW +: AW];
    if (hit(rs, ma_rd, ma_we)) return 2'd1;
    if (hit(rs, wb_rd, wb_we)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [1:0] exp_br(input int k);
    logic [AW-1:0] rs;
    rs = id_rs[k*AW +: AW];
    if (hit(rs, ex_rd, ex_we) && !ex_ld) return 2'd1;
    if (hit(rs, ma_rd, ma_we) && !ma_ld) return 2'd2;
    if (hit(rs, wb_rd, wb_we)) return 2'd3;
    return 2'd0;
  endfunction

  // Compare every cycle against the model, then advance the model across the coming edge.
  always @(negedge clk) begin : cmp_proc
    int n;
    bit es;
    logic [2*NS-1:0] ea, eb;
    if (chk_en) begin
      n = need_cycles();
      if (!rst_n || redirect) es = 1'b0;
      else if (m_rem > 0)     es = 1'b1;
      else                    es = (n > 0);
      ea = '0;
      eb = '0;
      for (int k = 0; k < NS; k++) begin
        ea[2*k +: 2] = exp_alu(k);
        eb[2*k +: 2] = exp_br(k);
      end
      chk("m_stall", 32'(stall), 32'(es));
      chk("m_bubble", 32'(bubble), 32'(es));
      chk("m_alu_sel", 32'(alu_sel), 32'(ea));
      chk("m_br_sel", 32'(br_sel), 32'(eb));
      chk("m_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
      if (!rst_n) begin
        m_rem = 0;
        m_cnt = 0;
      end else begin
        if (redirect)       m_rem = 0;
        else if (m_rem > 0) m_rem = m_rem - 1;
        else if (n > 0)     m_rem = n - 1;
        if (es && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    do_reset();

    // Reset values
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);

    // ALU forwarding priority and x0 exclusion
    cyc(); wb_rd = 5; wb_we = 1; ex_rs[4:0] = 5;
    @(negedge clk); chk("alu_wb", 32'(alu_sel[1:0]), 32'd2);
    cyc(); ma_rd = 5; ma_we = 1;
    @(negedge clk); chk("alu_ma", 32'(alu_sel[1:0]), 32'd1);
    cyc(); ma_rd = 0; wb_rd = 0; ex_rs[4:0] = 0;
    @(negedge clk); chk("alu_x0", 32'(alu_sel[1:0]), 32'd0);

    // Branch on ALU result in EX: forward from EX, no stall
    cyc(); clear_all(); ex_rd = 4; ex_we = 1; id_rs = {5'd0, 5'd4}; id_used = 2'b11; id_br = 1;
    @(negedge clk);
    chk("br_ex_sel", 32'(br_sel), 32'h1);
    chk("br_ex_nostall", 32'(stall), 32'd0);

    // Load-use: 1+LAT = 3 stall cycles
    do_reset();
    ex_rd = 1; ex_we = 1; ex_ld = 1; id_rs = {5'd2, 5'd1}; id_used = 2'b11;
    @(negedge clk); chk("lu_c1", 32'({stall, bubble}), 32'h3);
    cyc(); clear_ex();
    @(negedge clk); chk("lu_c2", 32'(stall), 32'd1);
    cyc();
    @(negedge clk); chk("lu_c3", 32'(stall), 32'd1);
    cyc(); ex_rs = {5'd2, 5'd1}; wb_rd = 1; wb_we = 1; id_rs = '0;
    @(negedge clk);
    chk("lu_end", 32'(stall), 32'd0);
    chk("lu_cnt", 32'(stall_cnt), 32'd3);
    chk("lu_alu_wb", 32'(alu_sel[1:0]), 32'd2);

    // Branch on load in EX: 2+LAT = 4 stall cycles, then WB forward
    do_reset();
    ex_rd = 1; ex_we = 1; ex_ld = 1; id_rs = {5'd2, 5'd1}; id_used = 2'b11; id_br = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("brl_stall", 32'(stall), 32'd1);
      cyc(); clear_ex();
    end
    wb_rd = 1; wb_we = 1;
    @(negedge clk);
    chk("brl_end", 32'(stall), 32'd0);
    chk("brl_br_sel", 32'(br_sel[1:0]), 32'd3);
    chk("brl_cnt", 32'(stall_cnt), 32'd4);

    // Redirect on the second stall cycle cancels the rest
    do_reset();
    ex_rd = 1; ex_we = 1; ex_ld = 1; id_rs = {5'd0, 5'd1}; id_used = 2'b01;
    @(negedge clk); chk("rd_c1", 32'(stall), 32'd1);
    cyc(); clear_ex(); redirect = 1;
    @(negedge clk); chk("rd_c2", 32'(stall), 32'd0);
    cyc(); redirect = 0;
    @(negedge clk);
    chk("rd_c3", 32'(stall), 32'd0);
    chk("rd_cnt", 32'(stall_cnt), 32'd1);

    // Reset in the middle of a STALL
    cyc(); ex_rd = 1; ex_we = 1; ex_ld = 1; id_br = 1;
    cyc(); clear_ex();
    @(negedge clk); chk("mr_stall", 32'(stall), 32'd1);
    cyc(); rst_n = 0;
    @(negedge clk); chk("mr_gate", 32'(stall), 32'd0);
    cyc(); rst_n = 1; clear_all();
    @(negedge clk);
    chk("mr_stall_after", 32'(stall), 32'd0);
    chk("mr_cnt", 32'(stall_cnt), 32'd0);

    // Continuous load-use for 20 cycles saturates the 4-bit counter
    cyc(); ex_rd = 3; ex_we = 1; ex_ld = 1; id_rs = {5'd0, 5'd3}; id_used = 2'b01;
    repeat (20) cyc();
    clear_all();
    @(negedge clk); chk("sat_cnt", 32'(stall_cnt), 32'hF);

    // Randomized traffic, model-checked every cycle
    for (int i = 0; i < 2000; i++) begin
      cyc();
      rst_n    = ($urandom_range(0, 99) != 0);
      redirect = ($urandom_range(0, 9) == 0);
      for (int k = 0; k < NS; k++) begin
        id_rs[k*AW +: AW] = AW'($urandom_range(0, 3));
        ex_rs[k*AW +: AW] = AW'($urandom_range(0, 3));
      end
      id_used = NS'($urandom_range(0, 3));
      id_br   = 1'($urandom_range(0, 1));
      ex_rd   = AW'($urandom_range(0, 3));
      ma_rd   = AW'($urandom_range(0, 3));
      wb_rd   = AW'($urandom_range(0, 3));
      ex_we   = ($urandom_range(0, 3) != 0);
      ma_we   = ($urandom_range(0, 3) != 0);
      wb_we   = ($urandom_range(0, 3) != 0);
      ex_ld   = 1'($urandom_range(0, 1));
      ma_ld   = 1'($urandom_range(0, 1));
    end
    cyc();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
